sha3_pad_scan_tx: RTL and testbench
===================================

# sha3_pad_scan_tx

Transmit-side feeder for the SHA3-256 sponge core's 136-bit scan input port. It accepts a byte-serial message, applies SHA3 multi-rate padding, and packs the bytes into 1088-bit rate blocks. Each block is emitted as eight 136-bit scan words, one pulse per word, and blocks are paced against the core's round completion. It sits between the host byte stream and the core's input buffer, and is the producer end of that scan interface.

## Interface
- No parameters; rate fixed at 1088 bits, 136 bytes per block, 8 words of 17 bytes each.
- clk  in  1  core clock; all logic is on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  byte offered.
- in_data  in  8  message byte.
- in_last  in  1  final beat of the message.
- in_keep  in  1  in_data is a real byte; in_keep=0 only legal with in_last=1 (empty tail / empty message).
- in_ready  out  1  byte accepted at posedge when in_valid && in_ready.
- core_ready  in  1  core has finished its 24 rounds on the previous block and may take a new one.
- scan_out  out  136  scan word; byte j of the word on bits [8j+7:8j].
- scan_valid  out  1  one-cycle pulse per word; the integrator drives the input buffer's scan strobe from it.
- block_done  out  1  pulse coincident with the 8th scan_valid of a block.
- last_block  out  1  high with block_done when the block carries the final padding.
- busy  out  1  high from the first accepted byte until the final block_done.

## Operation
- Block byte index b = 17k + j, where k is the word number (0..7) and j is the byte within the word. Word 0 is emitted first.
- States:
  - IDLE: in_ready=1. The first accepted beat goes to FILL, or to PAD if it is in_last with in_keep=0.
  - FILL: in_ready=1. Bytes go into the 17-byte assembly register.
    - On the 17th byte, the register is copied to scan_out and scan_valid pulses next cycle; assembly continues without a stall.
    - After word 7 is copied, go to WAIT_CORE.
    - An accepted in_last goes to PAD.
  - PAD: in_ready=0. Each cycle completes and emits one word:
    - The first pad byte, at b = message length mod 136, is 0x06.
    - Following bytes are 0x00.
    - Byte 135 is ORed with 0x80, so a single-byte pad is 0x86.
    - Emit words until word 7, then set last_block with block_done and return to IDLE.
  - WAIT_CORE: in_ready=0 until core_ready is sampled 1, then go to FILL.
    - Exception: if the message ended exactly on a block boundary, go instead to PAD with b=0, which produces a full extra padding block.
- Bytes are never reordered or dropped; the byte count wraps per block (0..135).

## Timing
- Reset values:
  - in_ready=0 during reset, 1 in the first cycle after reset (IDLE).
  - scan_out=0, scan_valid=0, block_done=0, last_block=0, busy=0.
  - Assembly register and counters cleared.
- Latency: the 17th byte of a word accepted at edge n gives scan_valid=1 in cycle n+1; scan_out holds stable until the next word.
- PAD emits one word per cycle; consecutive scan_valid pulses are allowed.
- core_ready is checked only in WAIT_CORE. A block is never started while core_ready=0.
- Reset mid-block aborts immediately: the partial block is discarded, no further scan_valid, and the block restarts from IDLE.
- in_valid while in_ready=0 is held by the source and has no effect.
- in_last with in_keep=1 on the 136th byte of a block: the byte is consumed, word 7 is emitted normally (last_block=0), then a full pad block follows after core_ready.

## Configuration
- PAD_KECCAK_LEGACY_EN defined: the first pad byte is 0x01 (original Keccak padding); a single-byte pad is 0x81.
- Undefined (default): SHA3 domain byte 0x06; a single-byte pad is 0x86. All other behaviour is identical.

## Test plan
- Empty message (in_last=1, in_keep=0 in IDLE):
  - Exactly 8 scan_valid pulses.
  - Word 0 byte 0 = 0x06, word 7 byte 16 = 0x80, all other bytes 0.
  - last_block=1 with block_done; busy drops next cycle.
- 135-byte message 0x00..0x86 with core_ready=1:
  - One block; byte 135 = 0x86; bytes 0..134 match the input.
  - scan_valid for word k one cycle after byte 17k+16 is accepted.
- 136-byte message:
  - Block 1 ends with block_done and last_block=0.
  - After core_ready, block 2 = 0x06, 0x00…, 0x80 with last_block=1.
  - 16 scan_valid pulses in total.
- 300-byte message with core_ready held 0 for 20 cycles after each block:
  - in_ready stays 0 for those 20 cycles; no scan_valid while waiting.
  - Data intact; 3 blocks; final pad byte at b=28.
- Reset asserted after 40 bytes of a block:
  - Next cycle all outputs are at reset values; no further scan_valid.
  - A following empty message produces the clean single pad block.
- With PAD_KECCAK_LEGACY_EN: the empty message gives word 0 byte 0 = 0x01; the 135-byte message gives byte 135 = 0x81.

Source files
------------

// File: rtl/sha3_pad_scan_tx.sv
// SHA3-256 scan-port feeder: pads a byte stream and emits 1088-bit rate blocks as eight 136-bit words.
// Optional macro PAD_KECCAK_LEGACY_EN selects the original Keccak pad byte 0x01 instead of 0x06.
module sha3_pad_scan_tx (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    input  logic         in_keep,
    output logic         in_ready,
    input  logic         core_ready,
    output logic [135:0] scan_out,
    output logic         scan_valid,
    output logic         block_done,
    output logic         last_block,
    output logic         busy
);

    localparam int unsigned BYTES_PER_WORD = 17;
    localparam int unsigned WORD_W         = 136;
    localparam int unsigned IDX_W          = 5;
    localparam int unsigned WORD_IDX_W     = 3;
`ifdef PAD_KECCAK_LEGACY_EN
    localparam logic [7:0] DOMAIN_BYTE = 8'h01;
`else
    localparam logic [7:0] DOMAIN_BYTE = 8'h06;
`endif
    localparam logic [IDX_W-1:0]      LAST_BYTE = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(7);

    typedef enum logic [1:0] {IDLE, FILL, PAD, WAIT_CORE} state_t;

    state_t                  state_q, state_n;
    logic [WORD_W-1:0]       asm_q, asm_n, asm_wr, pad_word;
    logic [IDX_W-1:0]        j_q, j_n;
    logic [WORD_IDX_W-1:0]   k_q, k_n;
    logic                    pad_first_q, pad_first_n;
    logic                    pad_pend_q, pad_pend_n;
    logic                    in_ready_q, in_ready_n;
    logic [WORD_W-1:0]       scan_out_q, scan_out_n;
    logic                    scan_valid_q, scan_valid_n;
    logic                    block_done_q, block_done_n;
    logic                    last_block_q, last_block_n;
    logic                    busy_q, busy_n;
    logic                    accept;

    assign accept = in_valid && in_ready_q;

    // Assembly register with the incoming byte dropped into slot j.
    always_comb begin
        asm_wr = asm_q;
        for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
            if (IDX_W'(i) == j_q) asm_wr[8*i +: 8] = in_data;
        end
    end

    // Word completed by padding: message bytes below j, domain byte at j on the first pad word, end bit on word 7.
    always_comb begin
        pad_word = '0;
        for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
            if (IDX_W'(i) < j_q)
                pad_word[8*i +: 8] = asm_q[8*i +: 8];
            else if (IDX_W'(i) == j_q && pad_first_q)
                pad_word[8*i +: 8] = DOMAIN_BYTE;
        end
        if (k_q == LAST_WORD) pad_word[WORD_W-1 -: 8] = pad_word[WORD_W-1 -: 8] | 8'h80;
    end

    always_comb begin
        state_n      = state_q;
        asm_n        = asm_q;
        j_n          = j_q;
        k_n          = k_q;
        pad_first_n  = pad_first_q;
        pad_pend_n   = pad_pend_q;
        scan_out_n   = scan_out_q;
        scan_valid_n = 1'b0;
        block_done_n = 1'b0;
        last_block_n = 1'b0;
        busy_n       = (block_done_q && last_block_q) ? 1'b0 : busy_q;

        case (state_q)
            IDLE, FILL: begin
                if (accept) begin
                    busy_n = 1'b1;
                    if (state_q == IDLE) pad_pend_n = 1'b0;
                    if (!in_keep) begin
                        // Empty tail: padding starts at the current byte position.
                        if (in_last) begin
                            state_n     = PAD;
                            pad_first_n = 1'b1;
                        end
                    end else if (j_q == LAST_BYTE) begin
                        scan_out_n   = asm_wr;
                        scan_valid_n = 1'b1;
                        asm_n        = '0;
                        j_n          = '0;
                        if (k_q == LAST_WORD) begin
                            block_done_n = 1'b1;
                            k_n          = '0;
                            pad_pend_n   = in_last;
                            state_n      = WAIT_CORE;
                        end else begin
                            k_n     = k_q + WORD_IDX_W'(1);
                            state_n = in_last ? PAD : FILL;
                            pad_first_n = in_last;
                        end
                    end else begin
                        asm_n       = asm_wr;
                        j_n         = j_q + IDX_W'(1);
                        state_n     = in_last ? PAD : FILL;
                        pad_first_n = in_last;
                    end
                end
            end
            PAD: begin
                scan_out_n   = pad_word;
                scan_valid_n = 1'b1;
                asm_n        = '0;
                j_n          = '0;
                pad_first_n  = 1'b0;
                if (k_q == LAST_WORD) begin
                    block_done_n = 1'b1;
                    last_block_n = 1'b1;
                    k_n          = '0;
                    pad_pend_n   = 1'b0;
                    state_n      = IDLE;
                end else begin
                    k_n = k_q + WORD_IDX_W'(1);
                end
            end
            WAIT_CORE: begin
                if (core_ready) begin
                    j_n = '0;
                    k_n = '0;
                    if (pad_pend_q) begin
                        state_n     = PAD;
                        pad_first_n = 1'b1;
                        pad_pend_n  = 1'b0;
                    end else begin
                        state_n = FILL;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        in_ready_n = (state_n == IDLE) || (state_n == FILL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            asm_q        <= '0;
            j_q          <= '0;
            k_q          <= '0;
            pad_first_q  <= 1'b0;
            pad_pend_q   <= 1'b0;
            in_ready_q   <= 1'b0;
            scan_out_q   <= '0;
            scan_valid_q <= 1'b0;
            block_done_q <= 1'b0;
            last_block_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_n;
            asm_q        <= asm_n;
            j_q          <= j_n;
            k_q          <= k_n;
            pad_first_q  <= pad_first_n;
            pad_pend_q   <= pad_pend_n;
            in_ready_q   <= in_ready_n;
            scan_out_q   <= scan_out_n;
            scan_valid_q <= scan_valid_n;
            block_done_q <= block_done_n;
            last_block_q <= last_block_n;
            busy_q       <= busy_n;
        end
    end

    assign in_ready   = in_ready_q;
    assign scan_out   = scan_out_q;
    assign scan_valid = scan_valid_q;
    assign block_done = block_done_q;
    assign last_block = last_block_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sha3_pad_scan_tx.sv
// Directed bench for sha3_pad_scan_tx: padding, block pacing, latency and mid-block reset.
module tb_sha3_pad_scan_tx;

`ifdef PAD_KECCAK_LEGACY_EN
    localparam logic [7:0] DOM = 8'h01;
`else
    localparam logic [7:0] DOM = 8'h06;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_last = 1'b0;
    logic         in_keep = 1'b0;
    logic         in_ready;
    logic         core_ready = 1'b1;
    logic [135:0] scan_out;
    logic         scan_valid;
    logic         block_done;
    logic         last_block;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc [0:511];

    logic [135:0] wq[$];
    bit           bdq[$];
    bit           lbq[$];
    int           cq[$];
    bit           hold_mode = 1'b0;
    int           hold_cnt = 0;
    int           hold_viol = 0;
    int           hold_periods = 0;

    sha3_pad_scan_tx dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_keep(in_keep), .in_ready(in_ready),
        .core_ready(core_ready), .scan_out(scan_out), .scan_valid(scan_valid),
        .block_done(block_done), .last_block(last_block), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Word capture and core_ready throttling when hold_mode is set.
    always @(negedge clk) begin
        if (scan_valid === 1'b1) begin
            wq.push_back(scan_out);
            bdq.push_back(block_done);
            lbq.push_back(last_block);
            cq.push_back(cyc);
        end
        if (hold_cnt > 0) begin
            if (in_ready !== 1'b0 || scan_valid !== 1'b0) hold_viol++;
            hold_cnt--;
            if (hold_cnt == 0) core_ready = 1'b1;
        end else if (hold_mode && block_done === 1'b1 && last_block === 1'b0) begin
            core_ready = 1'b0;
            hold_cnt = 20;
            hold_periods++;
        end
    end

    task automatic send_beat(input logic [7:0] d, input bit last, input bit keep, output int acc);
        int t;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last; in_keep = keep;
        t = 0;
        while (in_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
        end
        @(posedge clk);
        #1;
        acc = cyc;
        in_valid = 1'b0; in_last = 1'b0; in_keep = 1'b0;
    endtask

    task automatic send_msg(input int len);
        int a;
        if (len == 0) send_beat(8'h00, 1'b1, 1'b0, a);
        for (int i = 0; i < len; i++) begin
            send_beat(8'(i), i == len - 1, 1'b1, a);
            acc_cyc[i] = a;
        end
    endtask

    task automatic wait_last_done(input string name);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(block_done === 1'b1 && last_block === 1'b1) && t < 3000);
        if (t >= 3000) begin
            checks++; errors++;
            $display("FAIL %s_final_timeout: no last block_done within %0d cycles", name, t);
        end
    endtask

    // Flat padded-message reference, sliced into 17-byte words.
    task automatic check_blocks(input int base, input int len, input string name);
        logic [7:0]   p [0:543];
        logic [135:0] exp_w;
        int nblk = len / 136 + 1;
        int nw = 8 * nblk;
        for (int i = 0; i < 544; i++) p[i] = (i < len) ? 8'(i) : 8'h00;
        p[len] = DOM;
        p[nblk*136 - 1] = p[nblk*136 - 1] | 8'h80;
        checks++;
        if (wq.size() - base !== nw) begin
            errors++;
            $display("FAIL %s_word_count: got %0d words, required %0d", name, wq.size() - base, nw);
        end
        for (int w = 0; w < nw; w++) begin
            if (base + w < wq.size()) begin
                for (int j = 0; j < 17; j++) exp_w[8*j +: 8] = p[17*w + j];
                checks++;
                if (wq[base+w] !== exp_w || bdq[base+w] !== (w % 8 == 7) || lbq[base+w] !== (w == nw - 1)) begin
                    errors++;
                    $display("FAIL %s_word%0d: got %h bd=%b lb=%b, required %h bd=%b lb=%b", name, w,
                             wq[base+w], bdq[base+w], lbq[base+w], exp_w, (w % 8 == 7), (w == nw - 1));
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, scan_valid, block_done, last_block, busy} !== 5'b0 || scan_out !== 136'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b sv=%b bd=%b lb=%b busy=%b out=%h, required all 0",
                     in_ready, scan_valid, block_done, last_block, busy, scan_out);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got rdy=%b busy=%b, required rdy=1 busy=0", in_ready, busy);
        end
    endtask

    task automatic test_empty(input string name);
        int base = wq.size();
        send_msg(0);
        wait_last_done(name);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_at_done: got %b, required 1", name, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || block_done !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_after: got busy=%b bd=%b, required 0 0", name, busy, block_done);
        end
        repeat (3) @(negedge clk);
        check_blocks(base, 0, name);
    endtask

    task automatic test_135();
        int base = wq.size();
        send_msg(135);
        wait_last_done("m135");
        repeat (3) @(negedge clk);
        check_blocks(base, 135, "m135");
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (base + k >= cq.size() || cq[base+k] !== acc_cyc[17*k + 16]) begin
                errors++;
                $display("FAIL m135_latency_w%0d: scan_valid cycle %0d, required %0d", k,
                         (base + k < cq.size()) ? cq[base+k] : -1, acc_cyc[17*k + 16]);
            end
        end
    endtask

    task automatic test_136();
        int base = wq.size();
        send_msg(136);
        wait_last_done("m136");
        repeat (3) @(negedge clk);
        check_blocks(base, 136, "m136");
    endtask

    task automatic test_300_hold();
        int base = wq.size();
        hold_mode = 1'b1;
        send_msg(300);
        wait_last_done("m300");
        hold_mode = 1'b0;
        repeat (3) @(negedge clk);
        check_blocks(base, 300, "m300");
        checks++;
        if (hold_viol !== 0 || hold_periods !== 2) begin
            errors++;
            $display("FAIL m300_hold: violations=%0d periods=%0d, required 0 and 2", hold_viol, hold_periods);
        end
        // Final pad byte at block offset 28: word 1, byte 11 of block 3.
        checks++;
        if (base + 17 >= wq.size() || wq[base+17][95:88] !== DOM) begin
            errors++;
            $display("FAIL m300_pad_pos: got %h, required %h",
                     (base + 17 < wq.size()) ? wq[base+17][95:88] : 8'hxx, DOM);
        end
    endtask

    task automatic test_reset_mid();
        int a;
        int base;
        for (int i = 0; i < 40; i++) send_beat(8'(i), 1'b0, 1'b1, a);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, scan_valid, block_done, last_block, busy} !== 5'b0 || scan_out !== 136'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got rdy=%b sv=%b bd=%b lb=%b busy=%b out=%h, required all 0",
                     in_ready, scan_valid, block_done, last_block, busy, scan_out);
        end
        base = wq.size();
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (wq.size() !== base) begin
            errors++;
            $display("FAIL midreset_quiet: got %0d words, required 0", wq.size() - base);
        end
        test_empty("post_reset");
    endtask

    initial begin
        test_reset();
        test_empty("empty");
        test_135();
        test_136();
        test_300_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
